// File: rtl/tone_pkg.sv
// Shared types and constants for the tone scheduler: FSM states, key-to-pitch table
// and glide step size.
package tone_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SWITCH  = 2'd1,
    PLAY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [14:0] GLIDE_STEP = 15'd8;

  localparam logic [14:0] KEY_FREQ [8] = '{
    15'd262, 15'd294, 15'd330, 15'd349, 15'd392, 15'd440, 15'd494, 15'd523
  };

  // Keys beyond the table map to 0 Hz rather than indexing out of range.
  function automatic logic [14:0] key_freq(input int unsigned idx);
    logic [14:0] f;
    if (idx < 32'd8) f = KEY_FREQ[idx[2:0]];
    else f = 15'd0;
    return f;
  endfunction

  function automatic logic [14:0] glide_to(input logic [14:0] cur, input logic [14:0] tgt);
    logic [14:0] nxt;
    if (cur < tgt) nxt = ((tgt - cur) > GLIDE_STEP) ? (cur + GLIDE_STEP) : tgt;
    else if (cur > tgt) nxt = ((cur - tgt) > GLIDE_STEP) ? (cur - GLIDE_STEP) : tgt;
    else nxt = cur;
    return nxt;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Sample-rate tick generator: free-running 0..TICK_DIV-1 counter, tick high for the
// single cycle at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 2000
) (
  input  logic clk96M,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Divider counter, wraps after LAST.
  always_ff @(posedge clk96M or negedge reset_n) begin
    if (!reset_n) cnt_r <= '0;
    else if (cnt_r == LAST) cnt_r <= '0;
    else cnt_r <= cnt_r + CW'(1);
  end

  assign tick = (cnt_r == LAST);

endmodule

// File: rtl/tone_scheduler.sv
// Keyboard tone scheduler: per-tick key arbitration and muted frequency switching.
// Optional build macro TONE_SCHEDULER_GLIDE_EN replaces muted switching in PLAY by a glide.
module tone_scheduler
  import tone_pkg::*;
#(
  parameter int NKEYS      = 8,
  parameter int TICK_DIV   = 2000,
  parameter int MUTE_TICKS = 48
) (
  input  logic                     clk96M,
  input  logic                     reset_n,
  input  logic [NKEYS-1:0]         key,
  output logic [14:0]              freq,
  output logic                     mute,
  output logic [$clog2(NKEYS)-1:0] active_key,
  output logic                     busy
);

  localparam int KW = $clog2(NKEYS);
  localparam int MW = (MUTE_TICKS > 0) ? $clog2(MUTE_TICKS + 1) : 1;
  localparam logic [MW-1:0] MUTE_LOAD = MW'(MUTE_TICKS);

  logic             tick_s;
  state_t           state_r, state_s;
  logic [MW-1:0]    mute_cnt_r, mute_cnt_s;
  logic [KW-1:0]    pend_key_r, pend_key_s;
  logic [KW-1:0]    active_key_r, active_key_s;
  logic [14:0]      freq_r, freq_s;
  logic             mute_r, busy_r;
  logic [NKEYS-1:0] key_q_r, key_q_s;
  logic [NKEYS-1:0] rise_s;
  logic [KW-1:0]    rise_idx_s, held_idx_s, granted_s, win_s;
  logic             req_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk96M  (clk96M),
    .reset_n (reset_n),
    .tick    (tick_s)
  );

  // Arbiter: newest press wins, then the granted key if still held, then lowest held.
  always_comb begin
    rise_s     = key & ~key_q_r;
    rise_idx_s = '0;
    held_idx_s = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      rise_idx_s = rise_s[i] ? KW'(i) : rise_idx_s;
      held_idx_s = key[i] ? KW'(i) : held_idx_s;
    end
    granted_s = (state_r == SWITCH) ? pend_key_r : active_key_r;
    if (|rise_s) begin
      win_s = rise_idx_s;
      req_s = 1'b1;
    end else if (key[granted_s]) begin
      win_s = granted_s;
      req_s = 1'b1;
    end else if (|key) begin
      win_s = held_idx_s;
      req_s = 1'b1;
    end else begin
      win_s = '0;
      req_s = 1'b0;
    end
  end

  // Next-state logic; everything advances only on tick.
  always_comb begin
    state_s      = state_r;
    mute_cnt_s   = mute_cnt_r;
    pend_key_s   = pend_key_r;
    active_key_s = active_key_r;
    freq_s       = freq_r;
    key_q_s      = key_q_r;
    if (tick_s) begin
      key_q_s = key;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_s    = SWITCH;
            pend_key_s = win_s;
            mute_cnt_s = MUTE_LOAD;
          end else begin
            state_s = IDLE;
          end
        end
        SWITCH: begin
          if (!req_s) begin
            state_s    = RELEASE;
            mute_cnt_s = MUTE_LOAD;
          end else if (mute_cnt_r <= MW'(1)) begin
            state_s      = PLAY;
            mute_cnt_s   = '0;
            pend_key_s   = win_s;
            active_key_s = win_s;
            freq_s       = key_freq(32'(win_s));
          end else begin
            pend_key_s = win_s;
            mute_cnt_s = mute_cnt_r - MW'(1);
          end
        end
        PLAY: begin
          if (!req_s) begin
            state_s    = RELEASE;
            mute_cnt_s = MUTE_LOAD;
          end else begin
            if (win_s != active_key_r) begin
`ifdef TONE_SCHEDULER_GLIDE_EN
              active_key_s = win_s;
`else
              state_s    = SWITCH;
              pend_key_s = win_s;
              mute_cnt_s = MUTE_LOAD;
`endif
            end else begin
              state_s = PLAY;
            end
`ifdef TONE_SCHEDULER_GLIDE_EN
            freq_s = glide_to(freq_r, key_freq(32'(active_key_s)));
`endif
          end
        end
        RELEASE: begin
          if (req_s) begin
            state_s    = SWITCH;
            pend_key_s = win_s;
            mute_cnt_s = MUTE_LOAD;
          end else if (mute_cnt_r <= MW'(1)) begin
            state_s    = IDLE;
            mute_cnt_s = '0;
          end else begin
            mute_cnt_s = mute_cnt_r - MW'(1);
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk96M or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      mute_cnt_r   <= '0;
      pend_key_r   <= '0;
      active_key_r <= '0;
      freq_r       <= 15'd0;
      mute_r       <= 1'b1;
      busy_r       <= 1'b0;
      key_q_r      <= '0;
    end else begin
      state_r      <= state_s;
      mute_cnt_r   <= mute_cnt_s;
      pend_key_r   <= pend_key_s;
      active_key_r <= active_key_s;
      freq_r       <= freq_s;
      mute_r       <= (state_s != PLAY);
      busy_r       <= (state_s != IDLE);
      key_q_r      <= key_q_s;
    end
  end

  assign freq       = freq_r;
  assign mute       = mute_r;
  assign active_key = active_key_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed testbench for tone_scheduler with a short tick divider so a 48-tick mute
// window fits in a few hundred cycles.
module tb_tone_scheduler;

  localparam int TD = 4;

  logic        clk96M = 1'b0;
  logic        reset_n;
  logic [7:0]  key;
  logic [14:0] freq;
  logic        mute;
  logic [2:0]  active_key;
  logic        busy;

  int ncmp  = 0;
  int nfail = 0;
  logic [19:0] exp_v;
  wire  [19:0] obs = {busy, mute, active_key, freq};

  always #5 clk96M = ~clk96M;

  tone_scheduler #(.NKEYS(8), .TICK_DIV(TD), .MUTE_TICKS(48)) dut (
    .clk96M     (clk96M),
    .reset_n    (reset_n),
    .key        (key),
    .freq       (freq),
    .mute       (mute),
    .active_key (active_key),
    .busy       (busy)
  );

  // After reset release on a falling edge, every TD-th rising edge is a tick edge.
  task automatic do_ticks(input int n);
    repeat (n * TD) @(posedge clk96M);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    key     = 8'h00;
    repeat (3) @(posedge clk96M);
    #1;
    exp_v = {1'b0, 1'b1, 3'd0, 15'd0}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL reset_vals: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    @(negedge clk96M) reset_n = 1'b1;
    do_ticks(3);
    exp_v = {1'b0, 1'b1, 3'd0, 15'd0}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL idle_quiet: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
  endtask

  task automatic test_press_single;
    key = 8'h20;
    do_ticks(1);
    exp_v = {1'b1, 1'b1, 3'd0, 15'd0}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL press5_switch: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(47);
    exp_v = {1'b1, 1'b1, 3'd0, 15'd0}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL press5_mute47: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(1);
    exp_v = {1'b1, 1'b0, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL press5_play: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
  endtask

  task automatic test_switch_key;
    key = 8'h24;
    do_ticks(1);
    exp_v = {1'b1, 1'b1, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL press2_mute: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(47);
    exp_v = {1'b1, 1'b1, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL press2_mute47: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(1);
    exp_v = {1'b1, 1'b0, 3'd2, 15'd330}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL press2_play: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
  endtask

  task automatic test_release_return;
    key = 8'h20;
    do_ticks(1);
    exp_v = {1'b1, 1'b1, 3'd2, 15'd330}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL rel2_switch: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(48);
    exp_v = {1'b1, 1'b0, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL rel2_play5: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    key = 8'h00;
    do_ticks(1);
    exp_v = {1'b1, 1'b1, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL relall_release: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(47);
    exp_v = {1'b1, 1'b1, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL relall_47: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(1);
    exp_v = {1'b0, 1'b1, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL relall_idle: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
  endtask

  task automatic test_simultaneous;
    key = 8'h42;
    do_ticks(1);
    exp_v = {1'b1, 1'b1, 3'd5, 15'd440}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL sim_switch: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(48);
    exp_v = {1'b1, 1'b0, 3'd1, 15'd294}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL sim_play: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    key = 8'h4A;
    do_ticks(49);
    exp_v = {1'b1, 1'b0, 3'd3, 15'd349}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL rise3_play: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    key = 8'h52;
    do_ticks(49);
    exp_v = {1'b1, 1'b0, 3'd4, 15'd392}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL relpress_play: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(5);
    exp_v = {1'b1, 1'b0, 3'd4, 15'd392}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL hold_keep: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
  endtask

  task automatic test_reset_mid_switch;
    key = 8'hD2;
    do_ticks(10);
    exp_v = {1'b1, 1'b1, 3'd4, 15'd392}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL pre_reset_switch: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    reset_n = 1'b0;
    #1;
    exp_v = {1'b0, 1'b1, 3'd0, 15'd0}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL reset_async: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    key = 8'h00;
    repeat (4) @(posedge clk96M);
    @(negedge clk96M) reset_n = 1'b1;
    do_ticks(60);
    exp_v = {1'b0, 1'b1, 3'd0, 15'd0}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL post_reset_quiet: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
  endtask

  task automatic test_glide;
    key = 8'h01;
    do_ticks(49);
    exp_v = {1'b1, 1'b0, 3'd0, 15'd262}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL g_play0: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    key = 8'h02;
`ifdef TONE_SCHEDULER_GLIDE_EN
    for (int k = 1; k <= 4; k++) begin
      do_ticks(1);
      exp_v = {1'b1, 1'b0, 3'd1, 15'(262 + 8 * k)}; ncmp++;
      if (obs !== exp_v) begin nfail++; $display("FAIL g_step%0d: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", k, obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    end
    do_ticks(3);
    exp_v = {1'b1, 1'b0, 3'd1, 15'd294}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL g_saturate: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
`else
    do_ticks(1);
    exp_v = {1'b1, 1'b1, 3'd0, 15'd262}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL ng_switch: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
    do_ticks(48);
    exp_v = {1'b1, 1'b0, 3'd1, 15'd294}; ncmp++;
    if (obs !== exp_v) begin nfail++; $display("FAIL ng_play1: got b%0d m%0d k%0d f%0d want b%0d m%0d k%0d f%0d", obs[19], obs[18], obs[17:15], obs[14:0], exp_v[19], exp_v[18], exp_v[17:15], exp_v[14:0]); end
`endif
  endtask

  initial begin
    test_reset();
    test_press_single();
    test_switch_key();
    test_release_return();
    test_simultaneous();
    test_reset_mid_switch();
    test_glide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
